// File: rtl/mem_map_pkg.sv
// Shared address-map constants and enums for the segmented memory data port.
// Two data segments sit below SEG_B_TOP; the start-I/O flag lives at SEG_B_TOP.
package mem_map_pkg;

   localparam int unsigned SEG_A_TOP     = 32'd102;
   localparam int unsigned SEG_B_TOP     = 32'd202;
   localparam int unsigned START_IO_ADDR = SEG_B_TOP;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC_CPU = 2'd1,
      ACC_IO  = 2'd2,
      RESP    = 2'd3
   } arb_state_t;

   typedef enum logic {
      SRC_CPU = 1'b0,
      SRC_IO  = 1'b1
   } arb_src_t;

   typedef enum logic [1:0] {
      CLS_SEG_A = 2'd0,
      CLS_SEG_B = 2'd1,
      CLS_FLAG  = 2'd2,
      CLS_ERR   = 2'd3
   } addr_cls_t;

   function automatic logic cls_is_pass(input addr_cls_t cls);
      return (cls == CLS_SEG_A) || (cls == CLS_SEG_B);
   endfunction

endpackage

// File: rtl/arb_addr_decode.sv
// Combinational address classifier: data segment A/B (pass-through),
// start-I/O flag location, or out-of-map.
module arb_addr_decode
   import mem_map_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned A_TOP     = 102,
   parameter int unsigned FLAG_ADDR = 202
) (
   input  logic [WIDTH-1:0] addr,
   output addr_cls_t        cls
);

   localparam logic [WIDTH-1:0] A_TOP_W = WIDTH'(A_TOP);
   localparam logic [WIDTH-1:0] FLAG_W  = WIDTH'(FLAG_ADDR);

   // Classify the address against the map boundaries.
   always_comb begin
      cls = CLS_ERR;
      if (addr < A_TOP_W) begin
         cls = CLS_SEG_A;
      end else if (addr < FLAG_W) begin
         cls = CLS_SEG_B;
      end else if (addr == FLAG_W) begin
         cls = CLS_FLAG;
      end else begin
         cls = CLS_ERR;
      end
   end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares the memory data port between processor and I/O loader and owns the start-I/O flag.
// Define DATA_ARB_RR_EN for round-robin arbitration; otherwise the processor has fixed priority.
module data_port_arbiter
   import mem_map_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEG_A_TOP = mem_map_pkg::SEG_A_TOP,
   parameter int unsigned SEG_B_TOP = mem_map_pkg::SEG_B_TOP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wd,
   output logic             cpu_gnt,
   output logic             cpu_rvalid,
   output logic [WIDTH-1:0] cpu_rd,
   input  logic             io_req,
   input  logic             io_we,
   input  logic [WIDTH-1:0] io_addr,
   input  logic [WIDTH-1:0] io_wd,
   output logic             io_gnt,
   output logic             io_rvalid,
   output logic [WIDTH-1:0] io_rd,
   input  logic             io_start_set,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd,
   output logic             start_io,
   output logic             addr_err
);

   arb_state_t       state_q, state_d;
   arb_src_t         src_q, src_d;
   addr_cls_t        cls_q, cls_d;
   logic             we_q, we_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_a_q, mem_a_d;
   logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
   logic             cpu_gnt_q, cpu_gnt_d, io_gnt_q, io_gnt_d;
   logic             cpu_rvalid_q, cpu_rvalid_d, io_rvalid_q, io_rvalid_d;
   logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d, io_rd_q, io_rd_d;
   logic             start_io_q, start_io_d;
   logic             addr_err_q, addr_err_d;

   logic             win_io_s;
   logic             any_req_s;
   logic             win_we_s;
   logic [WIDTH-1:0] win_addr_s, win_wd_s;
   addr_cls_t        win_cls_s;
   logic [WIDTH-1:0] resp_data_s;

`ifdef DATA_ARB_RR_EN
   arb_src_t last_q, last_d;

   // The loader wins a tie only when the processor took the previous grant.
   always_comb begin
      win_io_s = io_req & (~cpu_req | (last_q == SRC_CPU));
   end
`else
   // Fixed priority: the loader is served only when the processor is idle.
   always_comb begin
      win_io_s = io_req & ~cpu_req;
   end
`endif

   assign any_req_s  = cpu_req | io_req;
   assign win_we_s   = win_io_s ? io_we   : cpu_we;
   assign win_addr_s = win_io_s ? io_addr : cpu_addr;
   assign win_wd_s   = win_io_s ? io_wd   : cpu_wd;

   arb_addr_decode #(
      .WIDTH     (WIDTH),
      .A_TOP     (SEG_A_TOP),
      .FLAG_ADDR (SEG_B_TOP)
   ) u_decode (
      .addr (win_addr_s),
      .cls  (win_cls_s)
   );

   // Next-state and registered-output computation for the access sequencer.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      cls_d        = cls_q;
      we_d         = we_q;
      mem_we_d     = 1'b0;
      mem_a_d      = mem_a_q;
      mem_wd_d     = mem_wd_q;
      cpu_gnt_d    = 1'b0;
      io_gnt_d     = 1'b0;
      cpu_rvalid_d = 1'b0;
      io_rvalid_d  = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (any_req_s) begin
               state_d   = win_io_s ? ACC_IO : ACC_CPU;
               src_d     = win_io_s ? SRC_IO : SRC_CPU;
               cls_d     = win_cls_s;
               we_d      = win_we_s;
               mem_a_d   = win_addr_s;
               mem_wd_d  = win_wd_s;
               mem_we_d  = win_we_s & cls_is_pass(win_cls_s);
               cpu_gnt_d = ~win_io_s;
               io_gnt_d  = win_io_s;
            end else begin
               state_d = IDLE;
            end
         end
         ACC_CPU: begin
            state_d      = RESP;
            cpu_rvalid_d = ~we_q;
         end
         ACC_IO: begin
            state_d     = RESP;
            io_rvalid_d = ~we_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef DATA_ARB_RR_EN
   // Remember who was granted last so ties alternate.
   always_comb begin
      last_d = last_q;
      if (cpu_gnt_d) begin
         last_d = SRC_CPU;
      end else if (io_gnt_d) begin
         last_d = SRC_IO;
      end else begin
         last_d = last_q;
      end
   end

   // Round-robin pointer; reset value lets the processor win the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= SRC_IO;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Read data seen by the requester during RESP, selected by the captured class.
   always_comb begin
      case (cls_q)
         CLS_SEG_A, CLS_SEG_B: resp_data_s = mem_rd;
         CLS_FLAG:             resp_data_s = {{(WIDTH-1){1'b0}}, start_io_q};
         default:              resp_data_s = {WIDTH{1'b0}};
      endcase
   end

   // Flag register, sticky error flag and held read data.
   always_comb begin
      start_io_d = start_io_q;
      addr_err_d = addr_err_q;
      if (io_start_set) begin
         start_io_d = 1'b1;
      end else if ((state_q == ACC_CPU) && we_q && (cls_q == CLS_FLAG)) begin
         start_io_d = mem_wd_q[0];
      end else begin
         start_io_d = start_io_q;
      end
      if (((state_q == ACC_CPU) || (state_q == ACC_IO)) && (cls_q == CLS_ERR)) begin
         addr_err_d = 1'b1;
      end else begin
         addr_err_d = addr_err_q;
      end
      cpu_rd_d = cpu_rvalid_q ? resp_data_s : cpu_rd_q;
      io_rd_d  = io_rvalid_q  ? resp_data_s : io_rd_q;
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         src_q        <= SRC_CPU;
         cls_q        <= CLS_SEG_A;
         we_q         <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_a_q      <= {WIDTH{1'b0}};
         mem_wd_q     <= {WIDTH{1'b0}};
         cpu_gnt_q    <= 1'b0;
         io_gnt_q     <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
         cpu_rd_q     <= {WIDTH{1'b0}};
         io_rd_q      <= {WIDTH{1'b0}};
         start_io_q   <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         cls_q        <= cls_d;
         we_q         <= we_d;
         mem_we_q     <= mem_we_d;
         mem_a_q      <= mem_a_d;
         mem_wd_q     <= mem_wd_d;
         cpu_gnt_q    <= cpu_gnt_d;
         io_gnt_q     <= io_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         io_rvalid_q  <= io_rvalid_d;
         cpu_rd_q     <= cpu_rd_d;
         io_rd_q      <= io_rd_d;
         start_io_q   <= start_io_d;
         addr_err_q   <= addr_err_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign cpu_gnt    = cpu_gnt_q;
   assign io_gnt     = io_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign io_rvalid  = io_rvalid_q;
   assign cpu_rd     = cpu_rvalid_q ? resp_data_s : cpu_rd_q;
   assign io_rd      = io_rvalid_q  ? resp_data_s : io_rd_q;
   assign start_io   = start_io_q;
   assign addr_err   = addr_err_q;

endmodule
